// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem responder and its storage array.
package dmem_pkg;

  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  localparam int CNT_W           = 4;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte storage with synchronous write and registered read; parity column
// is present only when DMEM_PARITY_EN is defined.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inj,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign idx = IDX_W'(32'(addr) % DEPTH);

  // Storage is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (en && we) mem[idx] <= wdata;
  end

  // A write echoes its own data so the response carries what was stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (en) rdata <= we ? wdata : mem[idx];
  end

`ifdef DMEM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) par[idx] <= even_par(wdata) ^ inj;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    err <= 1'b0;
    else if (en) err <= we ? 1'b0 : (even_par(mem[idx]) != par[idx]);
  end
`else
  logic unused_inj;
  assign unused_inj = inj;
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder with programmable wait states.
// Optional parity checking is enabled by defining DMEM_PARITY_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | ready for a request, nothing in flight
// ST_WAIT   | wait-state down-counter running
// ST_ACCESS | single cycle in which storage is read or written
// ST_RESP   | response held until the initiator takes it
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int DEPTH       = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              err_inject,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture;
  logic              we_q, inj_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              arr_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      inj_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= req_we;
      inj_q   <= err_inject;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          capture   = 1'b1;
          cnt_nxt   = WAIT_LD;
          state_nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        // <= guards against a stuck zero count ever trapping the FSM here
        if (cnt <= CNT_W'(1)) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_ACCESS),
    .we   (we_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .inj  (inj_q),
    .rdata(rsp_rdata),
    .err  (arr_err)
  );

  assign req_ready = rst & (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid & arr_err;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: instance 0 uses two wait states, instance 1 uses none.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst        [2];
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic       req_we     [2];
  logic [7:0] req_addr   [2];
  logic [7:0] req_wdata  [2];
  logic       err_inject [2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic [7:0] rsp_rdata  [2];
  logic       rsp_err    [2];
  logic       busy       [2];

  dmem_responder #(.WAIT_CYCLES(2), .DEPTH(256)) dut_w2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .err_inject(err_inject[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) dut_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .err_inject(err_inject[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

`ifdef DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: plain per-instance byte arrays plus a "corrupted parity" flag.
  logic [7:0] mdl   [2][256];
  bit         known [2][256];
  bit         bad   [2][256];

  function automatic int wc(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int w);
    chk("rst_rsp_valid", 32'(rsp_valid[w]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[w]), 32'd0);
    chk("rst_busy",      32'(busy[w]),      32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata[w]), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err[w]),   32'd0);
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic xact(input int w, input bit we, input logic [7:0] a, input logic [7:0] d,
                      input bit inj, input int hold, input bit intrude,
                      output logic [7:0] rd, output logic er, output int lat);
    chk("req_ready_idle", 32'(req_ready[w]), 32'd1);
    req_valid[w] = 1'b1; req_we[w] = we; req_addr[w] = a; req_wdata[w] = d; err_inject[w] = inj;
    @(negedge clk);
    req_valid[w] = 1'b0; req_we[w] = 1'b0; err_inject[w] = 1'b0;
    chk("busy_after_accept", 32'(busy[w]), 32'd1);
    lat = 0;
    while (!rsp_valid[w] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[w];
    er = rsp_err[w];
    if (intrude) begin
      req_valid[w] = 1'b1; req_we[w] = 1'b1; req_addr[w] = a; req_wdata[w] = 8'hEE;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid[w]), 32'd1);
      chk("hold_rsp_rdata", 32'(rsp_rdata[w]), 32'(rd));
      chk("hold_req_ready", 32'(req_ready[w]), 32'd0);
    end
    req_valid[w] = 1'b0; req_we[w] = 1'b0;
    rsp_ready[w] = 1'b1;
    @(negedge clk);
    rsp_ready[w] = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid[w]), 32'd0);
    chk("post_busy",      32'(busy[w]),      32'd0);
    chk("post_rsp_err",   32'(rsp_err[w]),   32'd0);
    chk("post_rdata_hold", 32'(rsp_rdata[w]), 32'(rd));
    if (intrude) begin
      @(negedge clk);
      chk("intrude_not_queued", 32'(busy[w]), 32'd0);
    end
  endtask

  task automatic run(input int w, input bit we, input logic [7:0] a, input logic [7:0] d,
                     input bit inj, input int hold, input bit intrude);
    logic [7:0] rd, exp_rd;
    logic       er, exp_er;
    int         lat;
    exp_rd = we ? d : mdl[w][a];
    exp_er = !we && PAR && bad[w][a];
    xact(w, we, a, d, inj, hold, intrude, rd, er, lat);
    chk("latency", 32'(lat), 32'(wc(w) + 1));
    chk("rsp_rdata", 32'(rd), 32'(exp_rd));
    chk("rsp_err", 32'(er), 32'(exp_er));
    if (we) begin
      mdl[w][a]   = d;
      known[w][a] = 1'b1;
      bad[w][a]   = inj;
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      rst[w] = 1'b0; req_valid[w] = 1'b0; req_we[w] = 1'b0; req_addr[w] = '0;
      req_wdata[w] = '0; err_inject[w] = 1'b0; rsp_ready[w] = 1'b0;
      for (int j = 0; j < 256; j++) begin
        mdl[w][j] = '0; known[w][j] = 1'b0; bad[w][j] = 1'b0;
      end
    end

    // Reset state
    @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(negedge clk);
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge clk);
    chk("ready_after_reset_w2", 32'(req_ready[0]), 32'd1);
    chk("ready_after_reset_w0", 32'(req_ready[1]), 32'd1);

    // Basic write/read at both latencies
    run(0, 1'b1, 8'h10, 8'hA5, 1'b0, 0, 1'b0);
    run(0, 1'b0, 8'h10, 8'h00, 1'b0, 0, 1'b0);
    run(1, 1'b1, 8'h10, 8'hA5, 1'b0, 0, 1'b0);
    run(1, 1'b0, 8'h10, 8'h00, 1'b0, 0, 1'b0);

    // Backpressure with an ignored second request
    run(0, 1'b0, 8'h10, 8'h00, 1'b0, 5, 1'b1);
    run(0, 1'b0, 8'h10, 8'h00, 1'b0, 0, 1'b0);

    // Reset during WAIT aborts the write
    run(0, 1'b1, 8'h20, 8'h5A, 1'b0, 0, 1'b0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h20; req_wdata[0] = 8'h3C;
    @(negedge clk);
    req_valid[0] = 1'b0; req_we[0] = 1'b0;
    chk("abort_in_wait_busy", 32'(busy[0]), 32'd1);
    rst[0] = 1'b0;
    #1;
    chk_reset_outputs(0);
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs(0);
    rst[0] = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 8'h20, 8'h00, 1'b0, 0, 1'b0);

    // Address boundary
    run(0, 1'b1, 8'hFF, 8'h77, 1'b0, 0, 1'b0);
    run(0, 1'b1, 8'h00, 8'h11, 1'b0, 0, 1'b0);
    run(0, 1'b0, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    run(0, 1'b0, 8'h00, 8'h00, 1'b0, 1, 1'b0);

    // Parity injection (err_inject ignored when parity is not built in)
    run(0, 1'b1, 8'h30, 8'h0F, 1'b1, 0, 1'b0);
    run(0, 1'b0, 8'h30, 8'h00, 1'b0, 2, 1'b0);
    run(0, 1'b1, 8'h30, 8'h0F, 1'b0, 0, 1'b0);
    run(0, 1'b0, 8'h30, 8'h00, 1'b0, 0, 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      int         w;
      bit         we;
      logic [7:0] a, d;
      w  = (k % 3 == 0) ? 1 : 0;
      a  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'(8'hF8 + 8'($urandom_range(0, 7)));
      d  = 8'($urandom_range(0, 255));
      we = ($urandom_range(0, 1) != 0) || !known[w][a];
      run(w, we, a, d, 1'b0, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states between request accept and memory access (legal 0..15).
REQ-002 Parameter DEPTH, default 256, number of 8-bit storage locations (address space 8 bits).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  8  byte address.
REQ-009 req_wdata  input  8  write data.
REQ-010 err_inject  input  1  when high at a write accept, corrupts the stored parity (used only with DMEM_PARITY_EN).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator takes the response.
REQ-013 rsp_rdata  output  8  read data; for writes, the data written.
REQ-014 rsp_err  output  1  parity error on the read response.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP.
REQ-017 IDLE: req_ready=1; req_valid&&req_ready SHALL capture we/addr/wdata/err_inject, load the wait counter with WAIT_CYCLES, and go to WAIT, or to ACCESS if WAIT_CYCLES=0.
REQ-018 WAIT: req_ready=0; the counter SHALL decrement each cycle; go to ACCESS on the cycle the counter equals 1.
REQ-019 ACCESS: a write SHALL update memory at the captured address exactly once; a read SHALL register mem[addr] into rsp_rdata; next state RESP.
REQ-020 RESP: rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready, then IDLE.
REQ-021 Latency: an accept at edge N SHALL give rsp_valid high after edge N+WAIT_CYCLES+1.
REQ-022 req_ready SHALL be 1 only in IDLE; requests presented in other states are ignored, not queued.
REQ-023 Addresses at or above DEPTH SHALL wrap modulo DEPTH.
REQ-024 A read following a write to the same address SHALL return the newly written data.
REQ-025 rsp_rdata SHALL hold its last value outside RESP; rsp_err SHALL be 0 outside RESP.

Reset
REQ-026 On rst low: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0 while reset is held.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 A reset asserted before ACCESS SHALL abort the transaction with no memory write; a reset during RESP SHALL drop the pending response.

Configuration
REQ-029 With DMEM_PARITY_EN defined: each location SHALL store an even-parity bit (^wdata, inverted if err_inject was captured high); a read SHALL set rsp_err when the recomputed parity differs from the stored bit.
REQ-030 Without DMEM_PARITY_EN: no parity storage; rsp_err SHALL be tied 0; err_inject SHALL be ignored.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the FSM state encoding, ADDR_W=8, DATA_W=8 and the default WAIT_CYCLES.
REQ-032 Storage SHALL be one sub-module, dmem_array (synchronous write, registered read, optional parity column); the FSM and counter SHALL live in dmem_responder.

Verification
REQ-033 WAIT_CYCLES=2: write 0xA5 to 0x10, then read 0x10 -> rsp_valid 3 cycles after each accept; read returns rsp_rdata=0xA5, rsp_err=0.
REQ-034 WAIT_CYCLES=0: read 0x10 -> rsp_valid on the cycle after accept, rsp_rdata=0xA5.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable, req_ready=0; a second req_valid during this time is ignored.
REQ-036 Write 0x3C to 0x20, assert rst in WAIT, release, read 0x20 -> previous contents returned (no write committed); outputs 0 during reset.
REQ-037 DMEM_PARITY_EN defined: write 0x0F with err_inject=1, then read -> rsp_err=1; a normal write and read of 0x0F -> rsp_err=0.
REQ-038 Write 0x77 to 0xFF, then write 0x11 to 0x00 and read 0xFF -> rsp_rdata=0x77 (no address aliasing across the boundary).
